// File: rtl/pkt_di_multi_checker_if.sv
// pkt_di_multi_checker_if: control, memory read ports and result bus of the packet data-integrity checker.
interface pkt_di_multi_checker_if #(parameter int ADDR_W = 14, parameter int NUM_CHK = 4);
  logic chk_en, pb_start, pb_irq, pb_crc_en;
  logic [7:0] pb_crc_val;
  logic [3:0] pb_data_sel, pb_byte_cnt;
  logic [ADDR_W-1:0] pb_addr_in, pb_addr_out, inmem_addr, outmem_addr;
  logic [4*NUM_CHK-1:0] chk_idx;
  logic [7:0] inmem_rdata, outmem_rdata;
  logic busy, done, crc_err;
  logic [NUM_CHK-1:0] di_err_mask, skip_mask;
  modport master (
    output chk_en, pb_start, pb_irq, pb_crc_en, pb_crc_val, pb_data_sel, pb_byte_cnt,
           pb_addr_in, pb_addr_out, chk_idx, inmem_rdata, outmem_rdata,
    input  inmem_addr, outmem_addr, busy, done, di_err_mask, skip_mask, crc_err
  );
  modport slave (
    input  chk_en, pb_start, pb_irq, pb_crc_en, pb_crc_val, pb_data_sel, pb_byte_cnt,
           pb_addr_in, pb_addr_out, chk_idx, inmem_rdata, outmem_rdata,
    output inmem_addr, outmem_addr, busy, done, di_err_mask, skip_mask, crc_err
  );
endinterface

// File: rtl/pkt_di_multi_checker.sv
// pkt_di_multi_checker: samples payload bytes and recomputes CRC-8 to verify packet builder output.
// Defining DI_CHK_ERR_CNT_EN adds saturating di_err_cnt / crc_err_cnt outputs.
module pkt_di_multi_checker #(
  parameter int ADDR_W = 14,
  parameter int NUM_CHK = 4,
  parameter logic [7:0] CRC_POLY = 8'h07,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  pkt_di_multi_checker_if.slave bus
`ifdef DI_CHK_ERR_CNT_EN
  , output logic [CNT_W-1:0] di_err_cnt,
  output logic [CNT_W-1:0] crc_err_cnt
`endif
);
  typedef enum logic [2:0] {IDLE, CAPTURE, CRC, WAIT_IRQ, COMPARE, REPORT} state_t;
  localparam logic [4:0] N = 5'(NUM_CHK);
  state_t st;
  logic [3:0] sel, bcnt, cur;
  logic [ADDR_W-1:0] ain, aout;
  logic [4*NUM_CHK-1:0] idx;
  logic [8*NUM_CHK-1:0] din;
  logic [NUM_CHK-1:0] skip;
  logic [7:0] crc;
  logic [4:0] c, s_cnt;
  logic crc_en, irq_seen, cur_skip;
  function automatic logic is_sel(input logic [3:0] m, input logic [3:0] i);
    return m == 4'd0 ? i[1:0] == 2'd0 : m == 4'd1 ? !i[1] : 1'b1;
  endfunction
  function automatic logic [3:0] pos(input logic [3:0] m, input logic [3:0] i);
    return m == 4'd0 ? {2'b0, i[3:2]} : m == 4'd1 ? {1'b0, i[3:2], i[0]} : i;
  endfunction
  // inverse of pos: the n-th selected payload index
  function automatic logic [3:0] nth(input logic [3:0] m, input logic [4:0] n);
    return m == 4'd0 ? {n[1:0], 2'b0} : m == 4'd1 ? {n[2:1], 1'b0, n[0]} : n[3:0];
  endfunction
  function automatic logic [7:0] crc8(input logic [7:0] c0, input logic [7:0] d);
    logic [7:0] r;
    r = c0 ^ d;
    for (int b = 0; b < 8; b++) r = r[7] ? {r[6:0], 1'b0} ^ CRC_POLY : {r[6:0], 1'b0};
    return r;
  endfunction
  assign s_cnt = sel == 4'd0 ? {3'b0, bcnt[3:2]} + 5'd1 :
                 sel == 4'd1 ? {2'b0, bcnt[3:2], 1'b0} + (bcnt[1:0] == 2'd0 ? 5'd1 : 5'd2) :
                 {1'b0, bcnt} + 5'd1;
  always_comb begin
    skip = '0;
    for (int k = 0; k < NUM_CHK; k++)
      skip[k] = !is_sel(sel, 4'(idx >> (4 * k))) || 4'(idx >> (4 * k)) > bcnt;
    cur = 4'(idx >> {c, 2'b00});
    cur_skip = 1'(skip >> c);
    bus.inmem_addr = st == CAPTURE && c < N ? ain + ADDR_W'(cur) :
                     st == CRC && c < s_cnt ? ain + ADDR_W'(nth(sel, c)) : '0;
    bus.outmem_addr = st == COMPARE && c < N && !cur_skip ? aout + ADDR_W'(2) + ADDR_W'(pos(sel, cur)) :
                      st == COMPARE && c == N ? aout + ADDR_W'(2) + ADDR_W'(s_cnt) : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= IDLE;
      c <= '0;
      sel <= '0;
      bcnt <= '0;
      ain <= '0;
      aout <= '0;
      idx <= '0;
      crc <= '0;
      crc_en <= 1'b0;
      irq_seen <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.di_err_mask <= '0;
      bus.skip_mask <= '0;
      bus.crc_err <= 1'b0;
    end else begin
      if (st != IDLE && bus.pb_irq) irq_seen <= 1'b1;
      case (st)
        IDLE: if (bus.pb_start && bus.chk_en) begin
          st <= CAPTURE;
          c <= '0;
          sel <= bus.pb_data_sel;
          bcnt <= bus.pb_byte_cnt;
          ain <= bus.pb_addr_in;
          aout <= bus.pb_addr_out;
          idx <= bus.chk_idx;
          crc_en <= bus.pb_crc_en;
          crc <= bus.pb_crc_en ? 8'h00 : bus.pb_crc_val;
          irq_seen <= 1'b0;
          bus.busy <= 1'b1;
          bus.di_err_mask <= '0;
          bus.skip_mask <= '0;
          bus.crc_err <= 1'b0;
        end
        CAPTURE: begin
          for (int k = 0; k < NUM_CHK; k++) if (c == 5'(k + 1)) din[8*k +: 8] <= bus.inmem_rdata;
          c <= c == N ? '0 : c + 5'd1;
          if (c == N) st <= crc_en ? CRC : WAIT_IRQ;
        end
        CRC: begin
          if (c != 5'd0) crc <= crc8(crc, bus.inmem_rdata);
          c <= c == s_cnt ? '0 : c + 5'd1;
          if (c == s_cnt) st <= WAIT_IRQ;
        end
        WAIT_IRQ: if (irq_seen) begin
          st <= COMPARE;
          bus.skip_mask <= skip;
        end
        COMPARE: begin
          for (int k = 0; k < NUM_CHK; k++)
            if (c == 5'(k + 1) && !skip[k] && bus.outmem_rdata != din[8*k +: 8]) bus.di_err_mask[k] <= 1'b1;
          c <= c == N + 5'd1 ? '0 : c + 5'd1;
          if (c == N + 5'd1) begin
            bus.crc_err <= bus.outmem_rdata != crc;
            bus.done <= 1'b1;
            st <= REPORT;
          end
        end
        REPORT: begin
          st <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
`ifdef DI_CHK_ERR_CNT_EN
  logic [CNT_W:0] di_sum, crc_sum;
  always_comb begin
    di_sum = {1'b0, di_err_cnt} + (CNT_W + 1)'($countones(bus.di_err_mask));
    crc_sum = {1'b0, crc_err_cnt} + (CNT_W + 1)'(bus.crc_err);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      di_err_cnt <= '0;
      crc_err_cnt <= '0;
    end else if (bus.done) begin
      di_err_cnt <= di_sum[CNT_W] ? '1 : di_sum[CNT_W-1:0];
      crc_err_cnt <= crc_sum[CNT_W] ? '1 : crc_sum[CNT_W-1:0];
    end
  end
`endif
endmodule

// File: doc/pkt_di_multi_checker.md
Name: pkt_di_multi_checker

Overview:
- Parametrised data-integrity and CRC checker for the packet builder.
- Per packet, samples NUM_CHK payload bytes from input memory and compares each against its packed position in output memory.
- Independently recomputes the packet CRC over the selected payload bytes and checks it against the CRC byte the builder wrote.
- Sits beside the packet builder; reads both memories through dedicated read ports.

Parameters:
- ADDR_W, 14, byte address width of both memories
- NUM_CHK, 4, number of sampled bytes checked per packet (1..8)
- CRC_POLY, 8'h07, CRC-8 polynomial; init 0x00, MSB-first, no reflection, no final XOR
- CNT_W, 16, error counter width (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- chk_en  in  1  enables acceptance of pb_start
- pb_start  in  1  packet build start pulse
- pb_irq  in  1  builder done pulse
- pb_crc_en  in  1  1: compute CRC; 0: expected CRC = pb_crc_val
- pb_crc_val  in  8  fixed CRC value used when pb_crc_en=0
- pb_data_sel  in  4  packing mode: 0 = lane0 of each word, 1 = lanes 0-1, others = all lanes
- pb_byte_cnt  in  4  index of last payload byte
- pb_addr_in  in  ADDR_W  payload base address in input memory
- pb_addr_out  in  ADDR_W  packet base address in output memory
- chk_idx  in  4*NUM_CHK  payload byte index per check; slot k = bits [4k+3:4k]
- inmem_addr  out  ADDR_W  input memory read address
- inmem_rdata  in  8  input memory byte; valid one cycle after address
- outmem_addr  out  ADDR_W  output memory read address
- outmem_rdata  in  8  output memory byte; valid one cycle after address
- busy  out  1  high when not in IDLE
- done  out  1  one-cycle pulse on REPORT
- di_err_mask  out  NUM_CHK  per-slot mismatch, valid with done
- skip_mask  out  NUM_CHK  per-slot index not selected by pb_data_sel or > pb_byte_cnt, valid with done
- crc_err  out  1  CRC mismatch, valid with done

Behaviour:
- Reset: state IDLE; all outputs 0; addresses 0; masks cleared.
- Selection:
  - mode 0: selected index i iff i%4==0; packed position p=i>>2.
  - mode 1: i%4 in {0,1}; p=(i>>2)*2+i[0].
  - other modes: all bytes; p=i.
- Address mapping:
  - Checked byte k lives at pb_addr_out+2+p.
  - CRC byte lives at pb_addr_out+2+S, where S = count of selected indices in 0..pb_byte_cnt.
- pb_data_sel, pb_byte_cnt, addresses, chk_idx, pb_crc_en and pb_crc_val are registered at start acceptance; later input changes are ignored until IDLE.
- IDLE: pb_start&&chk_en -> CAPTURE; otherwise stay. pb_start in any other state is ignored.
- CAPTURE:
  - Issues inmem_addr=pb_addr_in+chk_idx[k] for k=0..NUM_CHK-1, one per cycle, pipelined; data k is registered the following cycle.
  - After the last data -> CRC if crc_en, else expected CRC = pb_crc_val -> WAIT_IRQ.
- CRC:
  - Issues addresses for selected indices in ascending order, one per cycle; each returned byte updates the running CRC.
  - After the last selected byte's data -> WAIT_IRQ.
  - S=0 yields CRC 0x00.
- WAIT_IRQ: irq_seen is set by pb_irq in any non-IDLE state. A pulse arriving earlier than WAIT_IRQ is not lost. State waits while irq_seen=0, then -> COMPARE.
- COMPARE:
  - Issues output addresses for each non-skipped slot, then the CRC address, pipelined.
  - Slot mismatch sets its di_err_mask bit; CRC byte != expected sets crc_err.
  - Skipped slots never flag.
- REPORT: done=1 with masks for exactly one cycle -> IDLE. Masks hold until the next start acceptance.
- Unused address outputs drive 0.
- Reset mid-operation aborts to IDLE with no done.

Optional Feature:
- Macro DI_CHK_ERR_CNT_EN.
- When defined, adds outputs di_err_cnt and crc_err_cnt (CNT_W each). On each done:
  - di_err_cnt increments by popcount(di_err_mask).
  - crc_err_cnt increments by crc_err.
  - Both saturate at all-ones and clear only on reset.
- When undefined, neither port nor logic exists.

Test Plan:
- Mode 2, byte_cnt=1, payload 0x01,0x02, builder output hdr,hdr,0x01,0x02,0x1B, all chk_idx=0/1, crc_en=1 -> done, di_err_mask=0, crc_err=0.
- Same packet with outmem CRC byte 0x1C -> crc_err=1, di_err_mask=0.
- Mode 0, byte_cnt=8, chk_idx slot0=4, outmem[out+3]!=inmem[in+4] -> di_err_mask[0]=1; slot1=5 -> skip_mask[1]=1.
- Mode 1, byte_cnt=5, chk_idx=5 -> read outmem addr out+5; CRC read at out+2+4=out+6.
- crc_en=0, crc_val=0xA5, outmem CRC=0xA5, pb_irq pulsed during CAPTURE -> completes with crc_err=0, no hang.
- Reset asserted in CRC state -> busy=0 next cycle, no done; a new start runs a normal check.
